// File: rtl/map_pkg.sv
// map_pkg: shared word geometry and modulation-to-bytes-per-word lookup for the mapper path.
package map_pkg;
  localparam int WORD_BITS = 64;
  localparam int BYTE_BITS = 8;
  function automatic int bytes_per_word(input logic [63:0] m);
    return m == 64'("BPSK")   ? 1 :
           m == 64'("QPSK")   ? 2 :
           m == 64'("QAM16")  ? 4 :
           m == 64'("QAM64")  ? 6 :
           m == 64'("QAM256") ? 8 : 0;
  endfunction
endpackage

// File: rtl/map_byte_packer.sv
// map_byte_packer: packs a handshaked byte stream into 64-bit mapper words, LSB byte first,
// zero-padding and flushing the partial word at end of packet.
module map_byte_packer
  import map_pkg::*;
#(
  parameter int          DATA_BYTES_MAX = 8,
  parameter logic [63:0] MODULATION     = "BPSK"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BYTE_BITS-1:0] in_byte,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [WORD_BITS-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready
);
  localparam int N  = bytes_per_word(MODULATION);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (N == 0 || BYTE_BITS * DATA_BYTES_MAX != WORD_BITS) begin : g_bad_cfg
    $error("map_byte_packer: unsupported MODULATION or DATA_BYTES_MAX");
  end
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_BITS-1:0] acc_q, acc_d, out_data_q, out_data_d, word;
  logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                 xfer, done;
  assign in_ready  = !rst && (!out_valid_q || out_ready);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  // Bytes above cnt_q are always zero in acc_q, so OR-merging also pads a flushed word.
  always_comb begin
    xfer        = in_valid && in_ready;
    done        = xfer && (cnt_q == CW'(N - 1) || in_last);
    word        = acc_q | (WORD_BITS'(in_byte) << {cnt_q, 3'b000});
    acc_d       = done ? '0 : xfer ? word : acc_q;
    cnt_d       = done ? '0 : xfer ? cnt_q + CW'(1) : cnt_q;
    out_data_d  = done ? word : out_data_q;
    out_last_d  = done ? in_last : out_last_q;
    out_valid_d = done ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule

// File: tb/tb_map_byte_packer.sv
// tb_map_byte_packer: one packer per modulation driven side by side, each checked every cycle
// against a byte-queue model of word assembly plus directed constant checks.
module tb_map_byte_packer;
  localparam logic [63:0] MODS [5] = '{"BPSK", "QPSK", "QAM16", "QAM64", "QAM256"};
  localparam int NB [5] = '{1, 2, 4, 6, 8};
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ib [5];
  logic        iv [5], il [5], ir [5], ov [5], ol [5], ordy [5];
  logic [63:0] od [5];
  int n_vec = 0, n_err = 0;
  logic [7:0]  cur [5][$];
  logic [63:0] ed [5];
  logic        ev [5], el [5];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    map_byte_packer #(.DATA_BYTES_MAX(8), .MODULATION(MODS[g])) u_dut (
      .clk(clk), .rst(rst), .in_byte(ib[g]), .in_valid(iv[g]), .in_last(il[g]),
      .in_ready(ir[g]), .out_data(od[g]), .out_valid(ov[g]), .out_last(ol[g]),
      .out_ready(ordy[g])
    );
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      cur[i].delete();
      ed[i] = '0;
      ev[i] = 1'b0;
      el[i] = 1'b0;
    end
  endtask
  // Inputs are set at the falling edge; ready is checked before the rising edge, outputs after it.
  task automatic step();
    bit xi [5], xo [5];
    logic [63:0] w;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("in_ready[%0d]", i), 64'(ir[i]), 64'(!ev[i] || ordy[i]));
      xi[i] = iv[i] && (!ev[i] || ordy[i]);
      xo[i] = ev[i] && ordy[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (xi[i]) begin
        cur[i].push_back(ib[i]);
        if (cur[i].size() == NB[i] || il[i]) begin
          w = '0;
          foreach (cur[i][k]) w |= 64'(cur[i][k]) << (8 * k);
          ed[i] = w;
          ev[i] = 1'b1;
          el[i] = il[i];
          cur[i].delete();
        end else if (xo[i]) ev[i] = 1'b0;
      end else if (xo[i]) ev[i] = 1'b0;
      chk($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(ev[i]));
      if (ev[i]) begin
        chk($sformatf("out_data[%0d]", i), od[i], ed[i]);
        chk($sformatf("out_last[%0d]", i), 64'(ol[i]), 64'(el[i]));
      end
    end
  endtask
  task automatic cyc(input int i, input logic v, input logic [7:0] b, input logic l, input logic r);
    @(negedge clk);
    iv[i] = v;
    ib[i] = b;
    il[i] = l;
    ordy[i] = r;
    step();
    iv[i] = 1'b0;
    il[i] = 1'b0;
    ordy[i] = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 5; i++) begin
      ib[i] = '0; iv[i] = 1'b0; il[i] = 1'b0; ordy[i] = 1'b1;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst data[%0d]", i), od[i], 64'h0);
      chk($sformatf("rst valid[%0d]", i), 64'(ov[i]), 64'h0);
      chk($sformatf("rst last[%0d]", i), 64'(ol[i]), 64'h0);
      chk($sformatf("rst ready[%0d]", i), 64'(ir[i]), 64'h0);
    end
    rst = 1'b0;
    // QPSK two-byte word, one-cycle valid pulse
    cyc(1, 1, 8'hA5, 0, 1);
    cyc(1, 1, 8'h3C, 0, 1);
    chk("qpsk word", od[1], 64'h0000_0000_0000_3CA5);
    chk("qpsk valid", 64'(ov[1]), 64'h1);
    chk("qpsk last", 64'(ol[1]), 64'h0);
    cyc(1, 0, 8'h00, 0, 1);
    chk("qpsk pulse", 64'(ov[1]), 64'h0);
    // QAM64 back-to-back words
    for (int k = 1; k <= 12; k++) begin
      cyc(3, 1, 8'(k), 0, 1);
      if (k == 6) chk("qam64 word0", od[3], 64'h0000_0605_0403_0201);
      if (k == 12) chk("qam64 word1", od[3], 64'h0000_0C0B_0A09_0807);
    end
    // QAM16 single-byte packet, then next word restarts at byte 0
    cyc(2, 1, 8'h5A, 1, 1);
    chk("qam16 short", od[2], 64'h0000_0000_0000_005A);
    chk("qam16 last", 64'(ol[2]), 64'h1);
    for (int k = 0; k < 4; k++) cyc(2, 1, 8'hB0 + 8'(k), 0, 1);
    chk("qam16 next", od[2], 64'h0000_0000_B3B2_B1B0);
    // QAM256 backpressure
    for (int k = 0; k < 8; k++) cyc(4, 1, 8'h20 + 8'(k), 0, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(4, 1, 8'h28, 0, 0);
      chk("bp ready", 64'(ir[4]), 64'h0);
    end
    chk("bp word", od[4], 64'h2726_2524_2322_2120);
    chk("bp valid", 64'(ov[4]), 64'h1);
    cyc(4, 1, 8'h28, 0, 1);
    chk("bp drained", 64'(ov[4]), 64'h0);
    // Async reset mid-word
    for (int k = 0; k < 3; k++) cyc(4, 1, 8'h30 + 8'(k), 0, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst data", od[4], 64'h0);
    chk("arst valid", 64'(ov[4]), 64'h0);
    chk("arst last", 64'(ol[4]), 64'h0);
    chk("arst ready", 64'(ir[4]), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) cyc(4, 1, 8'h10 + 8'(k), 0, 1);
    chk("post-rst word", od[4], 64'h1716_1514_1312_1110);
    // BPSK: one word per byte
    cyc(0, 1, 8'hFF, 0, 1);
    chk("bpsk ff", od[0], 64'hFF);
    cyc(0, 1, 8'h00, 0, 1);
    chk("bpsk 00", od[0], 64'h00);
    chk("bpsk v", 64'(ov[0]), 64'h1);
    cyc(0, 1, 8'h81, 0, 1);
    chk("bpsk 81", od[0], 64'h81);
    // Random traffic on all packers at once
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        iv[i] = ($urandom % 4) != 0;
        ib[i] = 8'($urandom);
        il[i] = ($urandom % 8) == 0;
        ordy[i] = ($urandom % 4) != 0;
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
